// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming 3x3 neighbourhood generator for a raster-order
// pixel stream. Two line buffers hold the previous two lines. A 3x3 shift
// window presents p1..p9 to a downstream kernel stage.
// Optional feature macro: SOF_SYNC_EN adds the sof_in frame-start input.
//
// Handshake: a beat moves on an interface only in a cycle where both valid and
// ready are high. in_ready is a pure combinational function of out_valid and
// out_ready, so it never depends on in_valid. out_valid and p1..p9 hold steady
// until the consumer takes the window.
module window_gen_3x3 #(
    parameter int PIX_W = 4,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef SOF_SYNC_EN
    input  logic             sof_in,
`endif
    output logic [PIX_W-1:0] p1,
    output logic [PIX_W-1:0] p2,
    output logic [PIX_W-1:0] p3,
    output logic [PIX_W-1:0] p4,
    output logic [PIX_W-1:0] p5,
    output logic [PIX_W-1:0] p6,
    output logic [PIX_W-1:0] p7,
    output logic [PIX_W-1:0] p8,
    output logic [PIX_W-1:0] p9,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    // Raster position of the next pixel to be accepted
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Output window (index 0..8 = p1..p9) and status flags
    logic [PIX_W-1:0] win_q [9];
    logic [PIX_W-1:0] win_d [9];
    logic             out_valid_q, out_valid_d;
    logic             frame_done_q, frame_done_d;

    // Line buffers: lb0 holds line r-2, lb1 holds line r-1 at the current column
    logic [PIX_W-1:0] lb0_q [IMG_W];
    logic [PIX_W-1:0] lb1_q [IMG_W];

    logic             accept;
    logic             sof_hit;
    logic [COL_W-1:0] pos_col;
    logic [ROW_W-1:0] pos_row;
    logic [PIX_W-1:0] top_pix;
    logic [PIX_W-1:0] mid_pix;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef SOF_SYNC_EN
    assign sof_hit = accept && sof_in;
`else
    assign sof_hit = 1'b0;
`endif

    // A start-of-frame beat is forced to (0,0) regardless of the counters
    assign pos_col = sof_hit ? '0 : col_q;
    assign pos_row = sof_hit ? '0 : row_q;
    assign top_pix = lb0_q[pos_col];
    assign mid_pix = lb1_q[pos_col];

    // Next-state logic for counters, window and status flags
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        out_valid_d  = out_valid_q && !out_ready;
        frame_done_d = 1'b0;
        if (accept) begin
            // Shift every window row left; new column enters on the right
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = top_pix;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = mid_pix;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = pix_in;
            // Only windows fully inside the frame are emitted. The first two
            // rows and columns only prime the buffers and the window.
            out_valid_d  = !sof_hit && (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));
            frame_done_d = !sof_hit && (pos_row == ROW_LAST) && (pos_col == COL_LAST);
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == ROW_LAST) ? '0 : pos_row + ROW_W'(1);
            end else begin
                col_d = pos_col + COL_W'(1);
                row_d = pos_row;
            end
        end
    end

    // Control and window registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    // Line buffers rotate at the accepted column. They are not reset because
    // stale contents never reach an emitted window.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_q[pos_col] <= mid_pix;
            lb1_q[pos_col] <= pix_in;
        end
    end

    assign p1         = win_q[0];
    assign p2         = win_q[1];
    assign p3         = win_q[2];
    assign p4         = win_q[3];
    assign p5         = win_q[4];
    assign p6         = win_q[5];
    assign p7         = win_q[6];
    assign p8         = win_q[7];
    assign p9         = win_q[8];
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 with a 5x4 frame and pixel pattern (5r+c) mod 16.
// A cycle monitor keeps a reference model of out_valid, frame_done and the
// window queue. Each directed test also compares the captured windows against
// a hand-computed golden table.
module tb_window_gen_3x3;

  localparam int PW = 4;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int WW = 9 * PW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [PW-1:0] pix_in = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic sof_in = 1'b0;
  logic [PW-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic out_valid;
  logic out_ready = 1'b1;
  logic frame_done;
  logic [WW-1:0] win;

  assign win = {p1, p2, p3, p4, p5, p6, p7, p8, p9};

  window_gen_3x3 #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pix_in(pix_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
`ifdef SOF_SYNC_EN
    .sof_in(sof_in),
`endif
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5),
    .p6(p6), .p7(p7), .p8(p8), .p9(p9),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_done(frame_done)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] got_q[$];
  bit mdl_ov = 1'b0;
  bit mdl_fd = 1'b0;
  int mr = 0;
  int mc = 0;
  int fd_cnt = 0;
  bit done = 1'b0;

  typedef struct {
    int r;
    int c;
    logic [WW-1:0] win;
  } vec_t;
  vec_t golden[6];

  function automatic logic [PW-1:0] pat(input int r, input int c);
    return PW'((5 * r + c) % 16);
  endfunction

  function automatic logic [WW-1:0] exp_win(input int r, input int c);
    return {pat(r-2, c-2), pat(r-2, c-1), pat(r-2, c),
            pat(r-1, c-2), pat(r-1, c-1), pat(r-1, c),
            pat(r,   c-2), pat(r,   c-1), pat(r,   c)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  always @(negedge clk) begin
    bit acc;
    bit sof_now;
    bit nxt_ov;
    bit nxt_fd;
    int r;
    int c;
    if (!rst_n) begin
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_frame_done", 64'(frame_done), 64'(0));
      check("rst_window", 64'(win), 64'(0));
      mdl_ov = 1'b0;
      mdl_fd = 1'b0;
      mr = 0;
      mc = 0;
      exp_q.delete();
    end else begin
      check("out_valid", 64'(out_valid), 64'(mdl_ov));
      check("frame_done", 64'(frame_done), 64'(mdl_fd));
      check("in_ready", 64'(in_ready), 64'(!mdl_ov || out_ready));
      if (frame_done === 1'b1) fd_cnt++;
      if (mdl_ov) begin
        if (exp_q.size() == 0) begin
          check("window_unexpected", 64'(1), 64'(0));
        end else begin
          check("window", 64'(win), 64'(exp_q[0]));
          if (out_ready) begin
            got_q.push_back(win);
            void'(exp_q.pop_front());
          end
        end
      end
`ifdef SOF_SYNC_EN
      sof_now = sof_in;
`else
      sof_now = 1'b0;
`endif
      acc = in_valid && (!mdl_ov || out_ready);
      nxt_ov = mdl_ov && !out_ready;
      nxt_fd = 1'b0;
      if (acc) begin
        r = sof_now ? 0 : mr;
        c = sof_now ? 0 : mc;
        nxt_ov = !sof_now && r >= 2 && c >= 2;
        nxt_fd = !sof_now && r == H - 1 && c == W - 1;
        if (nxt_ov) exp_q.push_back(exp_win(r, c));
        if (c == W - 1) begin
          mc = 0;
          mr = (r == H - 1) ? 0 : r + 1;
        end else begin
          mc = c + 1;
          mr = r;
        end
      end
      mdl_ov = nxt_ov;
      mdl_fd = nxt_fd;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pix(input logic [PW-1:0] v, input logic sof, input int max_gap);
    int gap;
    int t;
    bit ok;
    gap = $urandom_range(max_gap, 0);
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    pix_in = v;
    sof_in = sof;
    in_valid = 1'b1;
    ok = 1'b0;
    t = 0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    sof_in = 1'b0;
    if (!ok) check("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_part(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      send_pix(pat(i / W, i % W), 1'b0, max_gap);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_golden(input string tag, input int n);
    logic [WW-1:0] g;
    check({tag, "_count"}, 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      g = got_q[i];
      check($sformatf("%s_win%0d", tag, i), 64'(g), 64'(golden[i % 6].win));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [WW-1:0] g;
    golden[0] = '{2, 2, 36'h012567ABC};
    golden[1] = '{2, 3, 36'h123678BCD};
    golden[2] = '{2, 4, 36'h234789CDE};
    golden[3] = '{3, 2, 36'h567ABCF01};
    golden[4] = '{3, 3, 36'h678BCD012};
    golden[5] = '{3, 4, 36'h789CDE123};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: one full frame, continuous input
    got_q.delete();
    fd_cnt = 0;
    send_part(W * H, 0);
    drain();
    check_golden("t1", 6);
    check("t1_frame_done_count", 64'(fd_cnt), 64'(1));

    // Test 2: hold off the first window for 4 cycles
    got_q.delete();
    fork
      send_part(W * H, 0);
      begin
        int t;
        t = 0;
        while (out_valid !== 1'b1 && t < 100) begin
          @(posedge clk);
          #1;
          t++;
        end
        if (t >= 100) check("t2_wait_window", 64'(0), 64'(1));
        out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("t2_in_ready_low", 64'(in_ready), 64'(0));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check_golden("t2", 6);

    // Test 3: random input gaps and output stalls over 3 frames
    got_q.delete();
    done = 1'b0;
    fork
      begin
        repeat (3) send_part(W * H, 2);
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(1, 0));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check_golden("t3", 18);

    // Test 4: reset in the middle of row 2, then a fresh frame
    send_part(12, 0);
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
    send_part(W * H, 0);
    drain();
    check_golden("t4", 6);

`ifdef SOF_SYNC_EN
    // Test 5: truncated frame followed by a start-of-frame resync
    got_q.delete();
    fd_cnt = 0;
    for (int i = 0; i < 7; i++) send_pix(PW'($urandom_range(15, 0)), 1'b0, 0);
    for (int i = 0; i < W * H; i++) send_pix(pat(i / W, i % W), i == 0, 0);
    drain();
    check_golden("t5", 6);
    check("t5_frame_done_count", 64'(fd_cnt), 64'(1));
`endif

    // Test 6: back-to-back frames, frame 2 carries no frame-1 data
    got_q.delete();
    send_part(W * H, 0);
    send_part(W * H, 0);
    drain();
    check_golden("t6", 12);
    if (got_q.size() > 6) begin
      g = got_q[6];
      check("t6_f2_p1", 64'(g[35:32]), 64'(0));
      check("t6_f2_p5", 64'(g[19:16]), 64'(6));
    end else begin
      check("t6_f2_present", 64'(got_q.size()), 64'(12));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
